// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and helpers for the BRAM FIFO read-side stream front end.
package fifo_stream_reader_pkg;

  localparam logic [2:0] BUF_DEPTH = 3'd2;

  // True when the committed word count (buffered + in flight - leaving) leaves room for one more.
  function automatic logic has_room(input logic [2:0] committed);
    return committed < BUF_DEPTH;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream seen by fifo_stream_reader.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 32
);
  logic             i_flush;
  logic             i_fifo_empty;
  logic             o_fifo_read;
  logic [WIDTH-1:0] i_fifo_rdata;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic [1:0]       o_level;

  modport master (
    input  i_flush, i_fifo_empty, i_fifo_rdata, i_ready,
    output o_fifo_read, o_valid, o_data, o_level
  );

  modport slave (
    output i_flush, i_fifo_empty, i_fifo_rdata, i_ready,
    input  o_fifo_read, o_valid, o_data, o_level
  );
endinterface

// File: rtl/fifo_stream_reader_stream_buffer2.sv
// Two-entry circular output buffer with push/pop/flush; flush overrides both.
module fifo_stream_reader_stream_buffer2
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    if (flush) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      occ_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = mem_q[rd_q];

  a_occ_bounded: assert property (@(posedge clk) disable iff (!rst_n) {1'b0, occ_q} <= BUF_DEPTH);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (occ_q != '0));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side front end for a BRAM FIFO: issues reads, absorbs the one-cycle read latency
// and presents popped words as a full-throughput valid/ready stream.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  fifo_stream_reader_if.master bus
);

  logic             inflight_q, inflight_d;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic             valid;
  logic             pop;
  logic             push;
  logic             fifo_read;
  logic [2:0]       committed;

  // The consumer's pop credits the issue rule, so reads continue back-to-back under i_ready.
  always_comb begin
    valid      = (occ != '0);
    pop        = valid & bus.i_ready;
    push       = inflight_q & ~bus.i_flush;
    committed  = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    fifo_read  = i_reset & ~bus.i_fifo_empty & ~bus.i_flush & has_room(committed);
    inflight_d = fifo_read;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_stream_reader_stream_buffer2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk      (i_clock),
    .rst_n    (i_reset),
    .push     (push),
    .push_data(bus.i_fifo_rdata),
    .pop      (pop),
    .flush    (bus.i_flush),
    .occ      (occ),
    .head     (head)
  );

  assign bus.o_fifo_read = fifo_read;
  assign bus.o_valid     = valid;
  assign bus.o_data      = head;
  assign bus.o_level     = occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: queue-based FIFO environment, queue reference model, directed tests.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(32)) bus ();

  fifo_stream_reader #(.WIDTH(32)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  // environment FIFO and reference model state
  logic [31:0] fifo_q[$];
  logic [31:0] m_buf[$];
  int          m_inflight = 0;
  logic [31:0] m_inword = '0;
  logic [31:0] dlv[$];
  int          dlv_cyc[$];
  int          cyc = 0;
  int          n_reads = 0;
  int          mx_level = 0;

  logic        s_read, s_valid, s_ready, s_flush;
  logic [31:0] s_data;
  logic [1:0]  s_level;

  // compare process: every cycle, with inputs stable
  always @(negedge clk) begin
    int e_pop;
    int e_read;
    s_read  = bus.o_fifo_read;
    s_valid = bus.o_valid;
    s_data  = bus.o_data;
    s_level = bus.o_level;
    s_ready = bus.i_ready;
    s_flush = bus.i_flush;
    if (int'(s_level) > mx_level) mx_level = int'(s_level);
    if (!rst_n) begin
      m_buf.delete();
      m_inflight = 0;
      chk("rst_valid", s_valid, 0);
      chk("rst_read", s_read, 0);
      chk("rst_data", s_data, 0);
      chk("rst_level", s_level, 0);
    end else begin
      e_pop  = (m_buf.size() != 0 && s_ready) ? 1 : 0;
      e_read = (!bus.i_fifo_empty && !s_flush && (m_buf.size() + m_inflight - e_pop < 2)) ? 1 : 0;
      chk("valid", s_valid, (m_buf.size() != 0) ? 1 : 0);
      chk("level", s_level, m_buf.size());
      chk("fifo_read", s_read, e_read);
      if (m_buf.size() != 0) chk("data", s_data, m_buf[0]);
    end
  end

  // FIFO environment and model update at the clock edge
  always @(posedge clk) begin
    logic [31:0] w;
    cyc++;
    if (rst_n) begin
      if (s_valid && s_ready && !s_flush) begin
        dlv.push_back(s_data);
        dlv_cyc.push_back(cyc);
      end
      if (s_flush) begin
        m_buf.delete();
      end else begin
        if (m_buf.size() != 0 && s_ready) void'(m_buf.pop_front());
        if (m_inflight != 0) m_buf.push_back(m_inword);
      end
      m_inflight = s_read ? 1 : 0;
      if (s_read) begin
        if (fifo_q.size() == 0) begin
          chk("read_when_empty", 1, 0);
        end else begin
          w = fifo_q.pop_front();
          bus.i_fifo_rdata <= w;
          m_inword = w;
          n_reads++;
        end
      end
    end
  end

  initial bus.i_fifo_empty = 1'b1;
  always @(posedge clk) begin
    #2;
    bus.i_fifo_empty = (fifo_q.size() == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
  endtask

  task automatic drain();
    int k = 0;
    while (k < 100 && !(fifo_q.size() == 0 && m_inflight == 0 && m_buf.size() == 0)) begin
      tick();
      k++;
    end
    if (k >= 100) chk("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic chk_seq(input string nm, input logic [31:0] base, input int n);
    chk({nm, "_count"}, dlv.size(), n);
    for (int i = 0; i < n && i < dlv.size(); i++) chk({nm, "_word"}, dlv[i], base + 32'(i));
  endtask

  int er[6];
  int ev[6];
  logic [31:0] dv[6];
  logic [31:0] exp_d[6];

  initial begin
    int r0;
    int k;
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    tick();
    tick();
    chk("reset_valid_lit", bus.o_valid, 0);
    chk("reset_level_lit", bus.o_level, 0);
    rst_n = 1'b1;
    tick();

    // three words, consumer always ready
    bus.i_ready = 1'b1;
    fifo_q.push_back(32'h11);
    fifo_q.push_back(32'h22);
    fifo_q.push_back(32'h33);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      er[i] = int'(bus.o_fifo_read);
      ev[i] = int'(bus.o_valid);
      dv[i] = bus.o_data;
    end
    chk("a_read_pattern", {er[0][0], er[1][0], er[2][0], er[3][0], er[4][0], er[5][0]}, 6'b111000);
    chk("a_valid_pattern", {ev[0][0], ev[1][0], ev[2][0], ev[3][0], ev[4][0], ev[5][0]}, 6'b001110);
    chk("a_data0", dv[2], 32'h11);
    chk("a_data1", dv[3], 32'h22);
    chk("a_data2", dv[4], 32'h33);
    tick();
    drain();

    // backpressure: 16 words with consumer stalled
    bus.i_ready = 1'b0;
    r0 = n_reads;
    push_words(32'h100, 16);
    repeat (8) tick();
    chk("b_reads_stalled", n_reads - r0, 2);
    chk("b_level", bus.o_level, 2);
    chk("b_head_stable", bus.o_data, 32'h100);
    chk("b_valid", bus.o_valid, 1);
    dlv.delete();
    dlv_cyc.delete();
    bus.i_ready = 1'b1;
    drain();
    chk_seq("b_seq", 32'h100, 16);
    if (dlv_cyc.size() == 16) chk("b_no_gap", dlv_cyc[15] - dlv_cyc[0], 15);
    else chk("b_gap_count", dlv_cyc.size(), 16);

    // ready toggling every cycle
    dlv.delete();
    mx_level = 0;
    push_words(32'h200, 8);
    k = 0;
    while (k < 60 && dlv.size() < 8) begin
      bus.i_ready = (k % 2 == 0);
      tick();
      k++;
    end
    if (k >= 60) chk("c_timeout", 0, 1);
    bus.i_ready = 1'b1;
    drain();
    chk_seq("c_seq", 32'h200, 8);
    chk("c_max_level_ok", (mx_level <= 2), 1);

    // flush while full, then flush while streaming with a word in flight
    dlv.delete();
    bus.i_ready = 1'b0;
    push_words(32'h300, 10);
    repeat (5) tick();
    chk("d_level_full", bus.o_level, 2);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("d_flush1_valid", bus.o_valid, 0);
    chk("d_flush1_level", bus.o_level, 0);
    repeat (4) tick();
    chk("d_refill_level", bus.o_level, 2);
    chk("d_refill_head", bus.o_data, 32'h302);
    bus.i_ready = 1'b1;
    k = 0;
    while (k < 20 && !(bus.o_valid && bus.o_data == 32'h304)) begin
      tick();
      k++;
    end
    if (k >= 20) chk("d_wait_timeout", 0, 1);
    chk("d_stream_level", bus.o_level, 1);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("d_flush2_valid", bus.o_valid, 0);
    chk("d_flush2_level", bus.o_level, 0);
    drain();
    exp_d = '{32'h302, 32'h303, 32'h306, 32'h307, 32'h308, 32'h309};
    chk("d_count", dlv.size(), 6);
    for (int i = 0; i < 6 && i < dlv.size(); i++) chk("d_word", dlv[i], exp_d[i]);

    // asynchronous reset mid-stream
    dlv.delete();
    push_words(32'h400, 12);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("e_async_valid", bus.o_valid, 0);
    chk("e_async_read", bus.o_fifo_read, 0);
    chk_seq("e_pre", 32'h400, 3);
    dlv.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain();
    chk_seq("e_post", 32'h405, 7);

    // single word
    dlv.delete();
    fifo_q.push_back(32'h500);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      er[i] = int'(bus.o_fifo_read);
      ev[i] = int'(bus.o_valid);
      dv[i] = bus.o_data;
    end
    chk("f_read_pattern", {er[0][0], er[1][0], er[2][0], er[3][0], er[4][0], er[5][0]}, 6'b100000);
    chk("f_valid_pattern", {ev[0][0], ev[1][0], ev[2][0], ev[3][0], ev[4][0], ev[5][0]}, 6'b001000);
    chk("f_data", dv[2], 32'h500);
    tick();
    chk_seq("f_seq", 32'h500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
